// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : RV32E fetch stage. Issues in-order instruction-memory reads at
//               the current PC, tags each accepted request with its PC, pairs
//               returning data with that tag, and buffers the results for
//               decode behind a valid/ready handshake. A redirect flushes the
//               buffer and arranges for in-flight responses to be discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,              // asynchronous, active-low
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        pc_stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    output logic        if_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t C_DEPTH = cnt_t'(DEPTH);
    localparam cnt_t C_ONE   = cnt_t'(1);
    localparam ptr_t C_PINC  = ptr_t'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    cnt_t count_q, count_d;            // buffered instructions
    cnt_t outstanding_q, outstanding_d; // accepted, not yet answered
    cnt_t drop_q, drop_d;              // stale responses still to discard
    logic fault_q, fault_d;

    ptr_t tag_wr_q, tag_wr_d;
    ptr_t tag_rd_q, tag_rd_d;
    ptr_t buf_wr_q, buf_wr_d;
    ptr_t buf_rd_q, buf_rd_d;

    logic [31:0] tag_mem   [DEPTH];
    logic [31:0] buf_instr [DEPTH];
    logic [31:0] buf_pc    [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic          misaligned;
    logic [CW:0]   used;
    logic          credit_ok;
    logic          issue;
    logic          fire;
    logic          rsp_stale;
    logic          rsp_take;
    logic          pop;
    logic [CW:0]   stale_total;

    assign misaligned = (pc[1:0] != 2'b00);

    // Credits come from registered occupancy only; a same-cycle pop does not
    // open a slot until the next cycle.
    assign used      = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit_ok = (used < {1'b0, C_DEPTH});

    assign issue = rst && !redirect && !fault_q && !misaligned && credit_ok;
    assign fire  = issue && imem_req_ready;

    // During a redirect every arriving response belongs to the old stream.
    assign rsp_stale = imem_rsp_valid && (redirect || (drop_q != '0));
    // The outstanding guard ignores responses to requests lost by a reset.
    assign rsp_take  = imem_rsp_valid && !redirect && (drop_q == '0)
                       && (outstanding_q != '0);

    assign id_valid = (count_q != '0) && !redirect;
    assign pop      = id_valid && id_ready;

    assign imem_req_valid = issue;
    assign imem_req_addr  = pc;
    assign pc_stall       = !rst || (!fire && !redirect);
    assign if_fault       = fault_q;

    assign id_instr = buf_instr[buf_rd_q];
    assign id_pc    = buf_pc[buf_rd_q];

    assign stale_total = {1'b0, drop_q} + {1'b0, outstanding_q};

    // Next-state for counters, pointers and the fault flag.
    always_comb begin
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        fault_d       = fault_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        buf_wr_d      = buf_wr_q;
        buf_rd_d      = buf_rd_q;

        if (redirect) begin
            count_d       = '0;
            outstanding_d = '0;
            fault_d       = 1'b0;
            tag_wr_d      = '0;
            tag_rd_d      = '0;
            buf_wr_d      = '0;
            buf_rd_d      = '0;
            // Everything still in flight becomes stale; a response arriving
            // right now is one of those and is consumed immediately.
            if (imem_rsp_valid && (stale_total != '0)) begin
                drop_d = cnt_t'(stale_total - 1'b1);
            end else begin
                drop_d = cnt_t'(stale_total);
            end
        end else begin
            if (misaligned) begin
                fault_d = 1'b1;
            end

            if (rsp_stale) begin
                drop_d = drop_q - C_ONE;
            end

            if (fire) begin
                tag_wr_d = tag_wr_q + C_PINC;
            end
            if (rsp_take) begin
                tag_rd_d = tag_rd_q + C_PINC;
                buf_wr_d = buf_wr_q + C_PINC;
            end
            if (pop) begin
                buf_rd_d = buf_rd_q + C_PINC;
            end

            if (fire && !rsp_take) begin
                outstanding_d = outstanding_q + C_ONE;
            end else if (!fire && rsp_take) begin
                outstanding_d = outstanding_q - C_ONE;
            end

            if (rsp_take && !pop) begin
                count_d = count_q + C_ONE;
            end else if (!rsp_take && pop) begin
                count_d = count_q - C_ONE;
            end
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            fault_q       <= 1'b0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            buf_wr_q      <= '0;
            buf_rd_q      <= '0;
        end else begin
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fault_q       <= fault_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            buf_wr_q      <= buf_wr_d;
            buf_rd_q      <= buf_rd_d;
        end
    end

    // Storage arrays: tags on accept, {tag, data} on an accepted response.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_mem[tag_wr_q] <= pc;
        end
        if (rsp_take) begin
            buf_instr[buf_wr_q] <= imem_rsp_data;
            buf_pc[buf_wr_q]    <= tag_mem[tag_rd_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed bench for instruction_fetch with a fixed-latency
//               in-order memory model and a PC-stage model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] C_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        redirect;
    logic        pc_stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        if_fault;

    instruction_fetch #(.DEPTH(4)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .redirect       (redirect),
        .pc_stall       (pc_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_ready       (id_ready),
        .if_fault       (if_fault)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc;
    int          lat;
    logic [31:0] cur_pc;
    logic [31:0] exp_id_pc;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] req_log [$];
    logic [31:0] pop_log [$];
    logic        s_req, s_stall, s_idv, s_fault;
    logic [31:0] s_idpc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input logic [31:0] q [$], input int idx);
        return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive inputs, sample outputs mid-cycle, advance models.
    task automatic do_cycle(input logic redir, input logic [31:0] tgt);
        logic fired;
        pc       = cur_pc;
        redirect = redir;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = q_addr[0] ^ C_KEY;
            q_addr.delete(0);
            q_due.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #2;
        s_req   = imem_req_valid;
        s_stall = pc_stall;
        s_idv   = id_valid;
        s_idpc  = id_pc;
        s_fault = if_fault;
        fired   = imem_req_valid && imem_req_ready;
        if (imem_req_valid) chk("req_addr", imem_req_addr, cur_pc);
        chk("pc_stall", {31'b0, pc_stall}, {31'b0, !fired && !redir});
        if (fired) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + lat);
            req_log.push_back(imem_req_addr);
        end
        if (id_valid && id_ready) begin
            chk("id_pc", id_pc, exp_id_pc);
            chk("id_instr", id_instr, exp_id_pc ^ C_KEY);
            pop_log.push_back(id_pc);
            exp_id_pc = exp_id_pc + 32'd4;
        end
        if (redir) begin
            cur_pc    = tgt;
            exp_id_pc = tgt;
            pop_log.delete();
        end else if (!pc_stall) begin
            cur_pc = cur_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for n edges (checking reset outputs), then release mid-cycle.
    task automatic reset_dut(input int n, input logic [31:0] pc0);
        rst            = 1'b0;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        q_addr.delete();
        q_due.delete();
        cur_pc    = pc0;
        pc        = pc0;
        exp_id_pc = pc0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_id_valid",  {31'b0, id_valid},       32'd0);
            chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("rst_pc_stall",  {31'b0, pc_stall},       32'd1);
            chk("rst_fault",     {31'b0, if_fault},       32'd0);
        end
        rst = 1'b1;
        cyc = 0;
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; pc = '0; redirect = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        id_ready = 1'b1; lat = 1; cyc = 0;

        // Reset and streaming with a 1-cycle memory
        reset_dut(3, 32'h0);
        for (int i = 0; i < 14; i++) begin
            do_cycle(1'b0, 32'h0);
            if (i == 0) chk("first_req", {31'b0, s_req}, 32'd1);
            if (i < 2) chk("fill_idv", {31'b0, s_idv}, 32'd0);
            else       chk("stream_idv", {31'b0, s_idv}, 32'd1);
            chk("stream_stall", {31'b0, s_stall}, 32'd0);
        end
        chk("stream_pops", pop_log.size(), 32'd12);

        // Backpressure
        id_ready = 1'b0;
        reset_dut(2, 32'h0);
        repeat (8) do_cycle(1'b0, 32'h0);
        chk("bp_nreq",  req_log.size(), 32'd4);
        chk("bp_last",  log_at(req_log, 3), 32'hC);
        chk("bp_req",   {31'b0, s_req},   32'd0);
        chk("bp_stall", {31'b0, s_stall}, 32'd1);
        chk("bp_idv",   {31'b0, s_idv},   32'd1);
        chk("bp_idpc",  s_idpc, 32'h0);
        id_ready = 1'b1;
        repeat (10) do_cycle(1'b0, 32'h0);
        chk("bp_resume", log_at(req_log, 4), 32'h10);
        chk("bp_pops",   pop_log.size(), 32'd10);

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        reset_dut(2, 32'h0);
        repeat (2) do_cycle(1'b0, 32'h0);
        chk("rd_inflight", req_log.size(), 32'd2);
        do_cycle(1'b1, 32'h100);
        chk("rd_idv",   {31'b0, s_idv},   32'd0);
        chk("rd_req",   {31'b0, s_req},   32'd0);
        chk("rd_stall", {31'b0, s_stall}, 32'd0);
        repeat (10) do_cycle(1'b0, 32'h0);
        chk("rd_first",  log_at(pop_log, 0), 32'h100);
        chk("rd_second", log_at(pop_log, 1), 32'h104);

        // Redirect coinciding with a response while the buffer holds data
        lat = 1;
        reset_dut(2, 32'h0);
        repeat (5) do_cycle(1'b0, 32'h0);
        chk("rc_pre_idv", {31'b0, s_idv}, 32'd1);
        do_cycle(1'b1, 32'h200);
        chk("rc_idv", {31'b0, s_idv}, 32'd0);
        chk("rc_req", {31'b0, s_req}, 32'd0);
        repeat (8) do_cycle(1'b0, 32'h0);
        chk("rc_first",  log_at(pop_log, 0), 32'h200);
        chk("rc_second", log_at(pop_log, 1), 32'h204);

        // Misaligned PC, sticky fault, cleared by redirect
        reset_dut(2, 32'h6);
        do_cycle(1'b0, 32'h0);
        chk("mis_req0",   {31'b0, s_req},   32'd0);
        chk("mis_stall0", {31'b0, s_stall}, 32'd1);
        chk("mis_fault0", {31'b0, s_fault}, 32'd0);
        do_cycle(1'b0, 32'h0);
        chk("mis_fault1", {31'b0, s_fault}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, 32'h0);
            chk("mis_sticky", {31'b0, s_fault}, 32'd1);
            chk("mis_noreq",  {31'b0, s_req},   32'd0);
        end
        do_cycle(1'b1, 32'h20);
        chk("mis_rd_fault", {31'b0, s_fault}, 32'd1);
        do_cycle(1'b0, 32'h0);
        chk("mis_clr_fault", {31'b0, s_fault}, 32'd0);
        chk("mis_clr_req",   {31'b0, s_req},   32'd1);
        chk("mis_clr_addr",  log_at(req_log, 0), 32'h20);
        repeat (6) do_cycle(1'b0, 32'h0);
        chk("mis_first", log_at(pop_log, 0), 32'h20);

        // Asynchronous reset mid-cycle with three buffered entries
        id_ready = 1'b0;
        reset_dut(2, 32'h0);
        repeat (3) do_cycle(1'b0, 32'h0);
        imem_req_ready = 1'b0;
        do_cycle(1'b0, 32'h0);
        pc = cur_pc; redirect = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #2;
        chk("ar_pre_idv", {31'b0, id_valid},       32'd1);
        chk("ar_pre_req", {31'b0, imem_req_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_idv",   {31'b0, id_valid},       32'd0);
        chk("ar_req",   {31'b0, imem_req_valid}, 32'd0);
        chk("ar_stall", {31'b0, pc_stall},       32'd1);
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        reset_dut(2, 32'h0);
        repeat (8) do_cycle(1'b0, 32'h0);
        chk("ar_first", log_at(pop_log, 0), 32'h0);
        chk("ar_pops",  pop_log.size(), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
